// File: rtl/noc_pck_protocol_monitor.sv
// Passive per-VC packet protocol monitor: checks header/body/tail order and packet
// length bounds, capturing the first violation and counting all of them.
module noc_pck_protocol_monitor #(
    parameter int V            = 4,
    parameter int MIN_PCK_SIZE = 2,
    parameter int MAX_PCK_SIZE = 16,
    parameter int CNTw         = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flit_in_wr,
    input  logic            hdr_flg_in,
    input  logic            tail_flg_in,
    input  logic [V-1:0]    vc_num_in,
    input  logic            err_clr,
    output logic            err_valid,
    output logic [2:0]      err_code,
    output logic [V-1:0]    err_vc,
    output logic [CNTw-1:0] err_cycle,
    output logic [CNTw-1:0] err_cnt,
    output logic [V-1:0]    vc_active,
    output logic [CNTw-1:0] pck_cnt
);
    localparam int LW = $clog2(MAX_PCK_SIZE + 1) + 1;
    localparam logic [LW-1:0] LMIN = LW'(MIN_PCK_SIZE);
    localparam logic [LW-1:0] LMAX = LW'(MAX_PCK_SIZE);
    localparam logic [LW-1:0] LSAT = LW'(MAX_PCK_SIZE + 1);

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_HDR_ACT   = 3'd1;
    localparam logic [2:0] E_TAIL_IDLE = 3'd2;
    localparam logic [2:0] E_BODY_IDLE = 3'd3;
    localparam logic [2:0] E_SHORT     = 3'd4;
    localparam logic [2:0] E_LONG      = 3'd5;
    localparam logic [2:0] E_VC        = 3'd6;

    typedef enum logic {IDLE, ACTIVE} vc_st_e;

    vc_st_e          st_q   [V];
    vc_st_e          st_d   [V];
    logic [LW-1:0]   len_q  [V];
    logic [LW-1:0]   len_d  [V];
    logic            ovl_q  [V];
    logic            ovl_d  [V];

    logic            err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [V-1:0]    err_vc_q, err_vc_d;
    logic [CNTw-1:0] err_cycle_q, err_cycle_d;
    logic [CNTw-1:0] err_cnt_q, err_cnt_d;
    logic [CNTw-1:0] pck_cnt_q, pck_cnt_d;
    logic [CNTw-1:0] cyc_q, cyc_d;

    logic            onehot;
    logic [2:0]      code;
    logic            pck_inc;
    logic [LW-1:0]   len_nx;
    logic [LW-1:0]   len_sat;
    logic            vld_base;
    logic [CNTw-1:0] cnt_base;

    // Per-VC state transitions; at most one VC is selected per cycle.
    always_comb begin
        onehot  = (vc_num_in != '0) && ((vc_num_in & (vc_num_in - V'(1))) == '0);
        code    = E_NONE;
        pck_inc = 1'b0;
        len_nx  = '0;
        len_sat = '0;
        if (flit_in_wr && !onehot) code = E_VC;
        for (int i = 0; i < V; i++) begin
            st_d[i]  = st_q[i];
            len_d[i] = len_q[i];
            ovl_d[i] = ovl_q[i];
            if (flit_in_wr && onehot && vc_num_in[i]) begin
                len_nx  = len_q[i] + LW'(1);
                len_sat = (len_nx > LSAT) ? LSAT : len_nx;
                if (st_q[i] == IDLE) begin
                    if (hdr_flg_in) begin
                        len_d[i] = LW'(1);
                        ovl_d[i] = 1'b0;
                        if (tail_flg_in) begin
                            pck_inc = 1'b1;
                            if (MIN_PCK_SIZE > 1) code = E_SHORT;
                        end else begin
                            st_d[i] = ACTIVE;
                        end
                    end else begin
                        code = tail_flg_in ? E_TAIL_IDLE : E_BODY_IDLE;
                    end
                end else if (hdr_flg_in) begin
                    code     = E_HDR_ACT;
                    len_d[i] = LW'(1);
                    ovl_d[i] = 1'b0;
                    if (tail_flg_in) st_d[i] = IDLE;
                end else begin
                    len_d[i] = len_sat;
                    if (tail_flg_in) begin
                        st_d[i] = IDLE;
                        pck_inc = 1'b1;
                        if (len_nx < LMIN)                     code = E_SHORT;
                        else if (len_nx > LMAX && !ovl_q[i])   code = E_LONG;
                    end else if (len_nx > LMAX && !ovl_q[i]) begin
                        code     = E_LONG;
                        ovl_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // A clear in the same cycle as a new error still lets that error be captured.
    always_comb begin
        vld_base    = err_clr ? 1'b0 : err_valid_q;
        cnt_base    = err_clr ? '0 : err_cnt_q;
        err_valid_d = vld_base;
        err_cnt_d   = cnt_base;
        err_code_d  = err_code_q;
        err_vc_d    = err_vc_q;
        err_cycle_d = err_cycle_q;
        if (code != E_NONE) begin
            err_cnt_d = (&cnt_base) ? cnt_base : cnt_base + CNTw'(1);
            if (!vld_base) begin
                err_valid_d = 1'b1;
                err_code_d  = code;
                err_vc_d    = vc_num_in;
                err_cycle_d = cyc_q;
            end
        end
        pck_cnt_d = (pck_inc && !(&pck_cnt_q)) ? pck_cnt_q + CNTw'(1) : pck_cnt_q;
        cyc_d     = cyc_q + CNTw'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                st_q[i]  <= IDLE;
                len_q[i] <= '0;
                ovl_q[i] <= 1'b0;
            end
            err_valid_q <= 1'b0;
            err_code_q  <= E_NONE;
            err_vc_q    <= '0;
            err_cycle_q <= '0;
            err_cnt_q   <= '0;
            pck_cnt_q   <= '0;
            cyc_q       <= '0;
        end else begin
            for (int i = 0; i < V; i++) begin
                st_q[i]  <= st_d[i];
                len_q[i] <= len_d[i];
                ovl_q[i] <= ovl_d[i];
            end
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_vc_q    <= err_vc_d;
            err_cycle_q <= err_cycle_d;
            err_cnt_q   <= err_cnt_d;
            pck_cnt_q   <= pck_cnt_d;
            cyc_q       <= cyc_d;
        end
    end

    always_comb begin
        for (int i = 0; i < V; i++) vc_active[i] = (st_q[i] == ACTIVE);
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_vc    = err_vc_q;
    assign err_cycle = err_cycle_q;
    assign err_cnt   = err_cnt_q;
    assign pck_cnt   = pck_cnt_q;
endmodule

// File: tb/tb_noc_pck_protocol_monitor.sv
// Bench for noc_pck_protocol_monitor: directed scenarios plus random traffic
// compared against a packet-level reference model.
module tb_noc_pck_protocol_monitor;
    localparam int V = 4, MINP = 2, MAXP = 4, CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0, hdr = 1'b0, tail = 1'b0, clr = 1'b0;
    logic [V-1:0]  vc = '0;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [V-1:0]  err_vc, vc_active;
    logic [CW-1:0] err_cycle, err_cnt, pck_cnt;

    int nchk = 0, nerr = 0;

    noc_pck_protocol_monitor #(.V(V), .MIN_PCK_SIZE(MINP), .MAX_PCK_SIZE(MAXP), .CNTw(CW)) dut (
        .clk(clk), .reset(reset), .flit_in_wr(wr), .hdr_flg_in(hdr), .tail_flg_in(tail),
        .vc_num_in(vc), .err_clr(clr), .err_valid(err_valid), .err_code(err_code),
        .err_vc(err_vc), .err_cycle(err_cycle), .err_cnt(err_cnt),
        .vc_active(vc_active), .pck_cnt(pck_cnt));

    always #5 clk = ~clk;

    // Reference model: packets as open/closed with an unbounded flit count.
    bit            m_open [V];
    int            m_len  [V];
    bit            m_long [V];
    bit            m_valid;
    logic [2:0]    m_code;
    logic [V-1:0]  m_vc;
    logic [CW-1:0] m_ecyc, m_ecnt, m_pck, m_cyc;

    function automatic void model_reset();
        for (int k = 0; k < V; k++) begin m_open[k] = 0; m_len[k] = 0; m_long[k] = 0; end
        m_valid = 0; m_code = 0; m_vc = 0; m_ecyc = 0; m_ecnt = 0; m_pck = 0; m_cyc = 0;
    endfunction

    function automatic void model_step(logic w, logic h, logic t, logic [V-1:0] v, logic c);
        int code = 0;
        int i = 0;
        if (w) begin
            if ($countones(v) != 1) code = 6;
            else begin
                for (int k = 0; k < V; k++) if (v[k]) i = k;
                if (!m_open[i]) begin
                    if (h) begin
                        m_len[i] = 1; m_long[i] = 0;
                        if (t) begin m_pck = m_pck + 1; if (MINP > 1) code = 4; end
                        else m_open[i] = 1;
                    end else code = t ? 2 : 3;
                end else if (h) begin
                    code = 1; m_len[i] = 1; m_long[i] = 0;
                    if (t) m_open[i] = 0;
                end else begin
                    m_len[i]++;
                    if (t) begin
                        m_open[i] = 0; m_pck = m_pck + 1;
                        if (m_len[i] < MINP) code = 4;
                        else if (m_len[i] > MAXP && !m_long[i]) code = 5;
                    end else if (m_len[i] > MAXP && !m_long[i]) begin
                        code = 5; m_long[i] = 1;
                    end
                end
            end
        end
        if (c) begin m_valid = 0; m_ecnt = 0; end
        if (code != 0) begin
            if (m_ecnt != {CW{1'b1}}) m_ecnt = m_ecnt + 1;
            if (!m_valid) begin m_valid = 1; m_code = 3'(code); m_vc = v; m_ecyc = m_cyc; end
        end
        m_cyc = m_cyc + 1;
    endfunction

    function automatic logic [V-1:0] model_active();
        logic [V-1:0] a;
        for (int k = 0; k < V; k++) a[k] = m_open[k];
        return a;
    endfunction

    // Drives one cycle at the falling edge; returns at the next falling edge.
    task automatic send(logic w, logic h, logic t, logic [V-1:0] v, logic c);
        wr = w; hdr = h; tail = t; vc = v; clr = c;
        @(posedge clk);
        model_step(w, h, t, v, c);
        #1;
        wr = 0; hdr = 0; tail = 0; vc = '0; clr = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; wr = 0; hdr = 0; tail = 0; vc = '0; clr = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        nchk++; if (err_valid !== 1'b0) begin nerr++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
        nchk++; if (err_code !== 3'd0) begin nerr++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        nchk++; if (err_cnt !== '0) begin nerr++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        nchk++; if (pck_cnt !== '0) begin nerr++; $display("FAIL reset_pck_cnt: got %0d want 0", pck_cnt); end
        nchk++; if (vc_active !== '0) begin nerr++; $display("FAIL reset_vc_active: got %b want 0", vc_active); end
        nchk++; if (err_vc !== '0 || err_cycle !== '0) begin nerr++; $display("FAIL reset_err_vc_cycle: got %b/%0d want 0/0", err_vc, err_cycle); end
    endtask

    task automatic test_hdr_active();
        do_reset();
        while (m_cyc != 10) send(0, 0, 0, '0, 0);
        send(1, 1, 0, 4'b0010, 0);
        send(1, 1, 0, 4'b0010, 0);
        nchk++; if (err_valid !== 1'b1) begin nerr++; $display("FAIL hdr_act_valid: got %b want 1", err_valid); end
        nchk++; if (err_code !== 3'd1) begin nerr++; $display("FAIL hdr_act_code: got %0d want 1", err_code); end
        nchk++; if (err_vc !== 4'b0010) begin nerr++; $display("FAIL hdr_act_vc: got %b want 0010", err_vc); end
        nchk++; if (err_cycle !== 16'd11) begin nerr++; $display("FAIL hdr_act_cycle: got %0d want 11", err_cycle); end
        nchk++; if (vc_active !== 4'b0010) begin nerr++; $display("FAIL hdr_act_active: got %b want 0010", vc_active); end
        nchk++; if (err_cnt !== 16'd1) begin nerr++; $display("FAIL hdr_act_cnt: got %0d want 1", err_cnt); end
        send(1, 0, 1, 4'b0010, 1);
        nchk++; if (err_valid !== 1'b0 || vc_active !== '0) begin nerr++; $display("FAIL hdr_act_close: got valid=%b active=%b want 0/0", err_valid, vc_active); end
    endtask

    task automatic test_legal();
        logic [CW-1:0] p0;
        p0 = pck_cnt;
        send(1, 1, 0, 4'b0001, 0);
        send(1, 1, 0, 4'b0100, 0);
        send(1, 0, 0, 4'b0001, 0);
        send(1, 0, 1, 4'b0100, 0);
        send(1, 0, 1, 4'b0001, 0);
        nchk++; if (err_valid !== 1'b0) begin nerr++; $display("FAIL legal_valid: got %b want 0", err_valid); end
        nchk++; if (pck_cnt !== p0 + 16'd2) begin nerr++; $display("FAIL legal_pck: got %0d want %0d", pck_cnt, p0 + 16'd2); end
        nchk++; if (vc_active !== '0) begin nerr++; $display("FAIL legal_active: got %b want 0", vc_active); end
    endtask

    task automatic test_size();
        logic [CW-1:0] p0, cyc5;
        p0 = pck_cnt;
        send(1, 1, 1, 4'b1000, 0);
        nchk++; if (err_code !== 3'd4 || err_vc !== 4'b1000) begin nerr++; $display("FAIL short_code: got %0d/%b want 4/1000", err_code, err_vc); end
        nchk++; if (pck_cnt !== p0 + 16'd1) begin nerr++; $display("FAIL short_pck: got %0d want %0d", pck_cnt, p0 + 16'd1); end
        send(0, 0, 0, '0, 1);
        p0 = pck_cnt;
        send(1, 1, 0, 4'b0001, 0);
        for (int k = 0; k < 3; k++) send(1, 0, 0, 4'b0001, 0);
        nchk++; if (err_valid !== 1'b0) begin nerr++; $display("FAIL long_early: got valid=%b want 0 at 4 flits", err_valid); end
        cyc5 = m_cyc;
        send(1, 0, 0, 4'b0001, 0);
        send(1, 0, 1, 4'b0001, 0);
        nchk++; if (err_code !== 3'd5 || err_cnt !== 16'd1) begin nerr++; $display("FAIL long_code: got code=%0d cnt=%0d want 5/1", err_code, err_cnt); end
        nchk++; if (err_cycle !== cyc5) begin nerr++; $display("FAIL long_cycle: got %0d want %0d", err_cycle, cyc5); end
        nchk++; if (pck_cnt !== p0 + 16'd1 || vc_active !== '0) begin nerr++; $display("FAIL long_pck: got %0d/%b want %0d/0", pck_cnt, vc_active, p0 + 16'd1); end
    endtask

    task automatic test_bad_vc();
        send(1, 1, 0, 4'b0001, 1);
        send(1, 0, 0, 4'b0110, 0);
        send(1, 1, 1, 4'b0000, 0);
        nchk++; if (err_cnt !== 16'd2) begin nerr++; $display("FAIL badvc_cnt: got %0d want 2", err_cnt); end
        nchk++; if (err_code !== 3'd6 || err_vc !== 4'b0110) begin nerr++; $display("FAIL badvc_code: got %0d/%b want 6/0110", err_code, err_vc); end
        nchk++; if (vc_active !== 4'b0001) begin nerr++; $display("FAIL badvc_active: got %b want 0001", vc_active); end
        send(1, 0, 1, 4'b0001, 0);
        nchk++; if (err_cnt !== 16'd2 || vc_active !== '0) begin nerr++; $display("FAIL badvc_close: got cnt=%0d active=%b want 2/0", err_cnt, vc_active); end
    endtask

    task automatic test_clr_race();
        send(1, 0, 1, 4'b0010, 0);
        send(1, 0, 0, 4'b0100, 1);
        nchk++; if (err_valid !== 1'b1 || err_cnt !== 16'd1) begin nerr++; $display("FAIL race_valid: got %b/%0d want 1/1", err_valid, err_cnt); end
        nchk++; if (err_code !== 3'd3 || err_vc !== 4'b0100) begin nerr++; $display("FAIL race_code: got %0d/%b want 3/0100", err_code, err_vc); end
    endtask

    task automatic test_reset_mid();
        send(1, 1, 0, 4'b0001, 1);
        nchk++; if (vc_active !== 4'b0001) begin nerr++; $display("FAIL mid_pre: got %b want 0001", vc_active); end
        @(posedge clk);
        #3 reset = 1;
        #1;
        nchk++; if (vc_active !== '0 || err_cnt !== '0 || pck_cnt !== '0) begin nerr++; $display("FAIL mid_async: got active=%b cnt=%0d pck=%0d want 0", vc_active, err_cnt, pck_cnt); end
        @(negedge clk);
        reset = 0;
        model_reset();
        send(1, 0, 1, 4'b0001, 0);
        nchk++; if (err_code !== 3'd2 || err_vc !== 4'b0001 || err_cycle !== '0) begin nerr++; $display("FAIL mid_tail: got %0d/%b/%0d want 2/0001/0", err_code, err_vc, err_cycle); end
    endtask

    task automatic test_random();
        logic [V-1:0] v;
        logic h, t;
        int kind;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) v = V'($urandom_range(0, 15));
            else v = V'(1) << $urandom_range(0, V - 1);
            kind = $urandom_range(0, 5);
            h = (kind == 0) || (kind == 1);
            t = (kind == 1) || (kind == 2);
            send(($urandom_range(0, 4) != 0), h, t, v, ($urandom_range(0, 19) == 0));
            nchk++; if (vc_active !== model_active()) begin nerr++; $display("FAIL rnd_active[%0d]: got %b want %b", n, vc_active, model_active()); end
            nchk++; if (pck_cnt !== m_pck) begin nerr++; $display("FAIL rnd_pck[%0d]: got %0d want %0d", n, pck_cnt, m_pck); end
            nchk++; if (err_valid !== m_valid || err_cnt !== m_ecnt) begin nerr++; $display("FAIL rnd_err[%0d]: got %b/%0d want %b/%0d", n, err_valid, err_cnt, m_valid, m_ecnt); end
            nchk++; if (err_code !== m_code || err_vc !== m_vc || err_cycle !== m_ecyc) begin nerr++; $display("FAIL rnd_cap[%0d]: got %0d/%b/%0d want %0d/%b/%0d", n, err_code, err_vc, err_cycle, m_code, m_vc, m_ecyc); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hdr_active();
        test_legal();
        test_size();
        test_bad_vc();
        test_clr_race();
        test_reset_mid();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
